// File: rtl/parity_frame_tx.sv
// parity_frame_tx: accepts a parallel word over valid/ready and serialises it
// as start bit, data bits LSB first, even parity bit and stop bit.
// Every output is driven straight from a flop.
module parity_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              parity_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_out_q, tx_out_d;
    logic              frame_done_q, frame_done_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              bit_last;

    // Next-state logic: FSM sequencing, bit-time counter, bit index and shifter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bit_last = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered
    // yet still line up with the state they describe
    always_comb begin
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            default: tx_out_d = 1'b1;
        endcase
        frame_done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
        tx_ready_d   = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_out_q     <= 1'b1;
            frame_done_q <= 1'b0;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tx_out_q     <= tx_out_d;
            frame_done_q <= frame_done_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_out     = tx_out_q;
    assign parity_out = parity_q;
    assign frame_done = frame_done_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: directed, table-driven check of parity_frame_tx in its
// default configuration, plus a DATA_W=4 / CLKS_PER_BIT=1 instance.
module tb_parity_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_out, parity_out, busy, frame_done;

    logic [3:0] tx_data_b;
    logic       tx_valid_b;
    logic       tx_ready_b, tx_out_b, parity_out_b, busy_b, frame_done_b;

    int n_cmp;
    int n_err;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .parity_out (parity_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data_b),
        .tx_valid   (tx_valid_b),
        .tx_ready   (tx_ready_b),
        .tx_out     (tx_out_b),
        .parity_out (parity_out_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;   // bit k = k-th serial bit: start, d0..d7, parity, stop
        logic        par;
        logic        hold;    // keep tx_valid high through the frame
        logic        poke;    // one-cycle tx_valid pulse mid-frame
        int          gap;     // required idle cycles before this handshake, -1 = don't care
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word and wait (bounded) for the handshake edge.
    task automatic handshake(input logic [7:0] w, output int waited);
        tx_data  = w;
        tx_valid = 1'b1;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (tx_ready) break;
            waited++;
            if (waited > 200) begin
                chk("ready_timeout", 32'(tx_ready), 32'd1);
                break;
            end
        end
        waited++;
        @(posedge clk);
    endtask

    // Check every cycle of a 44-cycle frame; abort_at >= 0 asserts reset there.
    task automatic check_frame(input logic [10:0] fr, input logic par, input logic hold,
                               input logic poke, input int abort_at);
        for (int cyc = 0; cyc < 44; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tx_out", 32'(tx_out), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(tx_ready), 32'd1);
                chk("rst_done", 32'(frame_done), 32'd0);
                chk("rst_parity", 32'(parity_out), 32'd0);
                tx_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("rst_hold_done", 32'(frame_done), 32'd0);
                    chk("rst_hold_tx", 32'(tx_out), 32'd1);
                end
                rst_n = 1'b1;
                return;
            end
            chk("tx_out", 32'(tx_out), 32'(fr[cyc/4]));
            chk("busy", 32'(busy), 32'd1);
            chk("tx_ready", 32'(tx_ready), 32'd0);
            chk("frame_done", 32'(frame_done), (cyc == 43) ? 32'd1 : 32'd0);
            chk("parity_out", 32'(parity_out), 32'(par));
            if (hold) begin
                tx_data = 8'($urandom);
            end else if (poke && cyc == 10) begin
                tx_valid = 1'b1;
                tx_data  = 8'h01;
            end else begin
                tx_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int waited;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        tx_data    = '0;
        tx_valid   = 1'b0;
        tx_data_b  = '0;
        tx_valid_b = 1'b0;

        vecs[0] = '{8'hA5, 11'b1_0_10100101_0, 1'b0, 1'b0, 1'b0, -1};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0, 1'b1, 1'b0, 1'b1, -1};
        vecs[2] = '{8'h00, 11'b1_0_00000000_0, 1'b0, 1'b1, 1'b0, -1};
        vecs[3] = '{8'hFF, 11'b1_0_11111111_0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h7F, 11'b1_1_01111111_0, 1'b1, 1'b0, 1'b0, -1};

        repeat (3) @(negedge clk);
        chk("reset_tx_out", 32'(tx_out), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_parity", 32'(parity_out), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            handshake(vecs[i].data, waited);
            if (vecs[i].gap >= 0) chk("idle_gap", 32'(waited), 32'(vecs[i].gap));
            check_frame(vecs[i].frame, vecs[i].par, vecs[i].hold, vecs[i].poke, -1);
            if (vecs[i].poke) begin
                tx_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("poke_idle_busy", 32'(busy), 32'd0);
                    chk("poke_idle_tx", 32'(tx_out), 32'd1);
                    chk("poke_parity", 32'(parity_out), 32'(vecs[i].par));
                end
            end
        end
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during DATA bit 3 of 0x3C, then an intact 0x81 frame.
        handshake(8'h3C, waited);
        check_frame(11'b1_0_00111100_0, 1'b0, 1'b0, 1'b0, 17);
        @(negedge clk);
        handshake(8'h81, waited);
        check_frame(11'b1_0_10000001_0, 1'b0, 1'b0, 1'b0, -1);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(tx_ready), 32'd1);

        // Narrow instance: 0xB -> 0,1,1,0,1,1,1 one bit per cycle.
        begin
            logic [6:0] frb;
            frb = 7'b1_1_1011_0;
            @(negedge clk);
            chk("b_ready", 32'(tx_ready_b), 32'd1);
            tx_data_b  = 4'hB;
            tx_valid_b = 1'b1;
            @(posedge clk);
            for (int c = 0; c < 7; c++) begin
                @(negedge clk);
                tx_valid_b = 1'b0;
                tx_data_b  = 4'($urandom);
                chk("b_tx_out", 32'(tx_out_b), 32'(frb[c]));
                chk("b_busy", 32'(busy_b), 32'd1);
                chk("b_frame_done", 32'(frame_done_b), (c == 6) ? 32'd1 : 32'd0);
                chk("b_parity", 32'(parity_out_b), 32'd1);
            end
            @(negedge clk);
            chk("b_idle_busy", 32'(busy_b), 32'd0);
            chk("b_idle_tx", 32'(tx_out_b), 32'd1);
            chk("b_idle_ready", 32'(tx_ready_b), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
